// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, decodes 11-bit frames
// and queues good scan codes in a first-word-fall-through FIFO.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ps_clk,
    input  logic                          ps_data,
    input  logic                          rd_en,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [2:0]                    gpio
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronisers idle high so reset never fabricates a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   prev_clk_q;
    logic                   clk_s;
    logic                   data_s;
    logic                   fall;

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [CW-1:0]          cyc_q, cyc_d;
    logic [CW-1:0]          cyc_inc;
    logic                   timeout;
    logic                   parity_ok;
    logic                   push_req;

    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overflow_q, overflow_d;

    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   push_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            prev_clk_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps_data};
            prev_clk_q  <= clk_s;
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall   = prev_clk_q & ~clk_s;

    // Good frame: odd number of ones across data and parity bit.
    assign parity_ok = ^{shift_q, par_q};
    assign cyc_inc   = cyc_q + 1'b1;
    assign timeout   = (state_q != IDLE) && !fall && (cyc_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        cyc_d        = cyc_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        push_req     = 1'b0;

        if (fall) begin
            cyc_d = '0;
        end else if (state_q != IDLE) begin
            cyc_d = cyc_inc;
        end

        if (timeout) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
            cyc_d       = '0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = data_s;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!parity_ok) begin
                        parity_err_d = 1'b1;
                    end else if (!data_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign full  = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = rd_en && !empty;

    // When full, a simultaneous pop frees the slot the new byte lands in.
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push_req && full && !pop;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            cyc_q        <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            cyc_q        <= cyc_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_valid   = !empty;
    assign rx_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign gpio       = {data_s, clk_s, clk};

endmodule
